// File: rtl/branch_comparator.sv
// Registered branch/jump condition evaluator for the 16-bit core's PC-select path.
// Optional macro BRANCH_CMP_UNSIGNED_EN builds the BLTU/BGEU comparators; otherwise opcodes 2/3 return 0.
module branch_comparator #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] FirstInput,
  input  logic [WIDTH-1:0] SecondInput,
  input  logic [2:0]       OPCode,
  output logic             BranchComparison
);

  localparam logic [2:0] OP_BNE  = 3'd0;
  localparam logic [2:0] OP_BGE  = 3'd1;
  localparam logic [2:0] OP_BLTU = 3'd2;
  localparam logic [2:0] OP_BGEU = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_BLT  = 3'd5;
  localparam logic [2:0] OP_JAL  = 3'd6;
  localparam logic [2:0] OP_JALR = 3'd7;

  logic take_d;
  logic take_q;
  logic eq;
  logic lt_signed;

  assign eq        = (FirstInput == SecondInput);
  assign lt_signed = ($signed(FirstInput) < $signed(SecondInput));

`ifdef BRANCH_CMP_UNSIGNED_EN
  logic lt_unsigned;
  assign lt_unsigned = (FirstInput < SecondInput);
`endif

  always_comb begin
    take_d = 1'b0;
    case (OPCode)
      OP_BNE:  take_d = ~eq;
      OP_BGE:  take_d = ~lt_signed;
`ifdef BRANCH_CMP_UNSIGNED_EN
      OP_BLTU: take_d = lt_unsigned;
      OP_BGEU: take_d = ~lt_unsigned;
`else
      OP_BLTU: take_d = 1'b0;
      OP_BGEU: take_d = 1'b0;
`endif
      OP_BEQ:  take_d = eq;
      OP_BLT:  take_d = lt_signed;
      OP_JAL:  take_d = 1'b1;
      OP_JALR: take_d = 1'b1;
      default: take_d = 1'b0;
    endcase
  end

  // Reset wins over every opcode, jumps included, and drops any pending result.
  always_ff @(posedge CLK) begin
    if (!RST_N) take_q <= 1'b0;
    else        take_q <= take_d;
  end

  assign BranchComparison = take_q;

endmodule

// File: tb/tb_branch_comparator.sv
// Directed self-checking bench for branch_comparator; expectations follow BRANCH_CMP_UNSIGNED_EN.
module tb_branch_comparator;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] FirstInput;
  logic [15:0] SecondInput;
  logic [2:0]  OPCode;
  logic        BranchComparison;

  int passed = 0;
  int total  = 0;

  branch_comparator #(.WIDTH(16)) dut (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .FirstInput       (FirstInput),
    .SecondInput      (SecondInput),
    .OPCode           (OPCode),
    .BranchComparison (BranchComparison)
  );

  always #5 CLK = ~CLK;

  // Apply inputs at the falling edge, then sample 1 time unit after the next rising edge.
  task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge CLK);
    OPCode      = op;
    FirstInput  = a;
    SecondInput = b;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(3'd6, 16'd12, 16'd6);
      total++;
      if (BranchComparison !== 1'b0)
        $display("FAIL reset_hold_%0d: got %b expected 0", i, BranchComparison);
      else passed++;
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    total++;
    if (BranchComparison !== 1'b1)
      $display("FAIL reset_release_jal: got %b expected 1", BranchComparison);
    else passed++;
  endtask

  task automatic test_beq();
    drive(3'd4, 16'd16, 16'd16);
    total++;
    if (BranchComparison !== 1'b1) $display("FAIL beq_equal: got %b expected 1", BranchComparison);
    else passed++;
    drive(3'd4, 16'd16, 16'd4);
    total++;
    if (BranchComparison !== 1'b0) $display("FAIL beq_unequal: got %b expected 0", BranchComparison);
    else passed++;
  endtask

  task automatic test_blt();
    drive(3'd5, 16'd12, 16'd16);
    total++;
    if (BranchComparison !== 1'b1) $display("FAIL blt_less: got %b expected 1", BranchComparison);
    else passed++;
    drive(3'd5, 16'd12, 16'd6);
    total++;
    if (BranchComparison !== 1'b0) $display("FAIL blt_greater: got %b expected 0", BranchComparison);
    else passed++;
  endtask

  task automatic test_signed_boundary();
    drive(3'd5, 16'h8000, 16'h7FFF);
    total++;
    if (BranchComparison !== 1'b1) $display("FAIL blt_min_vs_max: got %b expected 1", BranchComparison);
    else passed++;
    drive(3'd1, 16'h8000, 16'h7FFF);
    total++;
    if (BranchComparison !== 1'b0) $display("FAIL bge_min_vs_max: got %b expected 0", BranchComparison);
    else passed++;
    drive(3'd5, 16'h1234, 16'h1234);
    total++;
    if (BranchComparison !== 1'b0) $display("FAIL blt_equal: got %b expected 0", BranchComparison);
    else passed++;
    drive(3'd1, 16'h1234, 16'h1234);
    total++;
    if (BranchComparison !== 1'b1) $display("FAIL bge_equal: got %b expected 1", BranchComparison);
    else passed++;
  endtask

  task automatic test_jump();
    drive(3'd6, 16'd12, 16'd6);
    total++;
    if (BranchComparison !== 1'b1) $display("FAIL jal: got %b expected 1", BranchComparison);
    else passed++;
    drive(3'd7, 16'd12, 16'd6);
    total++;
    if (BranchComparison !== 1'b1) $display("FAIL jalr: got %b expected 1", BranchComparison);
    else passed++;
  endtask

  task automatic test_unsigned();
    logic exp_a, exp_b, exp_c;
`ifdef BRANCH_CMP_UNSIGNED_EN
    exp_a = 1'b0; exp_b = 1'b1; exp_c = 1'b1;
`else
    exp_a = 1'b0; exp_b = 1'b0; exp_c = 1'b0;
`endif
    drive(3'd2, 16'h8000, 16'h0001);
    total++;
    if (BranchComparison !== exp_a) $display("FAIL bltu_8000_1: got %b expected %b", BranchComparison, exp_a);
    else passed++;
    drive(3'd3, 16'h8000, 16'h0001);
    total++;
    if (BranchComparison !== exp_b) $display("FAIL bgeu_8000_1: got %b expected %b", BranchComparison, exp_b);
    else passed++;
    drive(3'd2, 16'h0001, 16'h8000);
    total++;
    if (BranchComparison !== exp_c) $display("FAIL bltu_1_8000: got %b expected %b", BranchComparison, exp_c);
    else passed++;
  endtask

  // Consecutive single-cycle compares; expectations hand-computed.
  task automatic test_back_to_back();
    logic [2:0]  ops [10] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd5, 3'd4, 3'd6, 3'd5, 3'd1, 3'd0};
    logic [15:0] as  [10] = '{16'd5, 16'd5, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF, 16'hABCD};
    logic [15:0] bs  [10] = '{16'd5, 16'd6, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h8000, 16'h8000, 16'hABCC};
    logic        exp [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      drive(ops[i], as[i], bs[i]);
      total++;
      if (BranchComparison !== exp[i])
        $display("FAIL b2b_%0d op=%0d: got %b expected %b", i, ops[i], BranchComparison, exp[i]);
      else passed++;
    end
  endtask

  task automatic test_hold_and_midstream_reset();
    drive(3'd4, 16'd3, 16'd3);
    // Glitch inputs mid-cycle; output must keep the registered value.
    OPCode = 3'd4; SecondInput = 16'd9;
    #2;
    total++;
    if (BranchComparison !== 1'b1) $display("FAIL hold_glitch: got %b expected 1", BranchComparison);
    else passed++;
    SecondInput = 16'd3;
    @(negedge CLK);
    OPCode = 3'd6;
    RST_N  = 1'b0;
    @(posedge CLK);
    #1;
    total++;
    if (BranchComparison !== 1'b0) $display("FAIL midstream_reset: got %b expected 0", BranchComparison);
    else passed++;
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    total++;
    if (BranchComparison !== 1'b1) $display("FAIL after_midstream_reset: got %b expected 1", BranchComparison);
    else passed++;
  endtask

  initial begin
    RST_N       = 1'b0;
    OPCode      = 3'd0;
    FirstInput  = 16'd0;
    SecondInput = 16'd0;
    test_reset();
    test_beq();
    test_blt();
    test_signed_boundary();
    test_jump();
    test_unsigned();
    test_back_to_back();
    test_hold_and_midstream_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
